// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared loader state encoding and stack-CPU opcode constants
package cpu_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LEN   = 3'd1,
      DATA  = 3'd2,
      CSUM  = 3'd3,
      RUN   = 3'd4,
      ERROR = 3'd5
   } state_t;

   localparam logic [3:0] PUSHC = 4'b0000;
   localparam logic [3:0] PUSHM = 4'b0001;
   localparam logic [3:0] POP   = 4'b0010;
   localparam logic [3:0] HALT  = 4'b0011;
   localparam logic [3:0] ADD   = 4'b0110;
   localparam logic [3:0] SUB   = 4'b0111;

endpackage

// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed byte-stream loader into CPU instruction memory with checksum gate
module program_loader
   import cpu_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int MAX_LEN = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_load,
   output logic [ADDR_W-1:0] mem_address,
   output logic [7:0]        mem_data,
   output logic              cpu_en,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   state_t            state, next_state;
   logic [7:0]        remaining;
   logic [7:0]        csum;
   logic [ADDR_W-1:0] index;
   logic              accept;

   assign in_ready = (state == LEN) || (state == DATA) || (state == CSUM);
   // start takes priority: a byte presented alongside start is never consumed
   assign accept   = in_valid && in_ready && !start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (start) begin
         next_state = LEN;
      end else begin
         case (state)
            LEN: begin
               if (accept) begin
                  if (in_data == 8'd0 || in_data > MAX_LEN_B) next_state = ERROR;
                  else                                          next_state = DATA;
               end
            end
            DATA: begin
               if (accept && remaining == 8'd1) next_state = CSUM;
            end
            CSUM: begin
               if (accept) next_state = (in_data == csum) ? RUN : ERROR;
            end
            default: next_state = state;
         endcase
      end
   end

   // Status outputs track the state being entered so they line up with it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         remaining   <= '0;
         csum        <= '0;
         index       <= '0;
         mem_load    <= 1'b0;
         mem_address <= '0;
         mem_data    <= '0;
         cpu_en      <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
      end else begin
         mem_load <= 1'b0;
         done     <= 1'b0;
         cpu_en   <= (next_state == RUN);
         error    <= (next_state == ERROR);
         busy     <= (next_state == LEN) || (next_state == DATA) || (next_state == CSUM);
         if (start) begin
            remaining <= '0;
            csum      <= '0;
            index     <= '0;
         end else if (accept) begin
            case (state)
               LEN: remaining <= in_data;
               DATA: begin
                  mem_load    <= 1'b1;
                  mem_address <= index;
                  mem_data    <= in_data;
                  index       <= index + 1'b1;
                  csum        <= csum + in_data;
                  remaining   <= remaining - 8'd1;
               end
               CSUM: done <= (in_data == csum);
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed scoreboard bench for program_loader
module tb_program_loader;
   import cpu_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;

   logic       in_ready, mem_load, cpu_en, busy, done, error;
   logic [7:0] mem_address, mem_data;
   logic       in_ready2, mem_load2, cpu_en2, busy2, done2, error2;
   logic [7:0] mem_address2, mem_data2;

   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   logic [15:0] exp_q[$];
   logic [7:0]  prog [18] = '{8'h00, 8'h17, 8'h00, 8'h08, 8'h60, 8'h20, 8'h15, 8'h10, 8'h15,
                              8'h10, 8'h15, 8'h60, 8'h00, 8'h0C, 8'h70, 8'h00, 8'h0F, 8'h30};

   program_loader #(.ADDR_W(8), .MAX_LEN(255)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .mem_load(mem_load), .mem_address(mem_address), .mem_data(mem_data),
      .cpu_en(cpu_en), .busy(busy), .done(done), .error(error));

   program_loader #(.ADDR_W(8), .MAX_LEN(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready2), .mem_load(mem_load2), .mem_address(mem_address2), .mem_data(mem_data2),
      .cpu_en(cpu_en2), .busy(busy2), .done(done2), .error(error2));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (mem_load) begin
         check("en_during_load", cpu_en, 1'b0);
         if (exp_q.size() == 0) begin
            check("unexpected_write", {mem_address, mem_data}, 16'hxxxx);
         end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            check("write_addr", mem_address, e[15:8]);
            check("write_data", mem_data, e[7:0]);
         end
      end
   end

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      int n = 0;
      in_valid = 1'b1;
      in_data  = b;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("ready_wait", in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_data  = 8'hEE;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic frame(input logic [7:0] csum_b);
      send(8'd18);
      for (int i = 0; i < 18; i++) begin
         exp_q.push_back({8'(i), prog[i]});
         send(prog[i]);
      end
      send(csum_b);
   endtask

   initial begin
      int d0;
      #2;
      check("rst_load", mem_load, 1'b0);
      check("rst_outs", {in_ready, cpu_en, busy, done, error}, 5'b0);
      check("rst_addr", mem_address, 8'h00);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle_ready", in_ready, 1'b0);

      // good frame
      pulse_start();
      check("start_busy", {busy, in_ready}, 2'b11);
      frame(8'h19);
      check("good_run", {cpu_en, done, error, busy}, 4'b1100);
      check("good_q", exp_q.size(), 0);
      @(posedge clk); #1;
      check("good_hold", {cpu_en, done}, 2'b10);
      check("good_done_cnt", done_cnt, 1);

      // bad checksum
      pulse_start();
      check("restart_en", cpu_en, 1'b0);
      frame(8'h18);
      check("bad_err", {error, cpu_en, done}, 3'b100);
      @(posedge clk); #1;
      check("bad_done_cnt", done_cnt, 1);
      check("bad_q", exp_q.size(), 0);

      // zero length
      pulse_start();
      check("restart_err", error, 1'b0);
      send(8'd0);
      check("len0_err", {error, busy}, 2'b10);

      // MAX_LEN boundary on the 16-deep instance
      pulse_start();
      send(8'd16);
      check("len16_ok", {busy2, error2}, 2'b10);
      pulse_start();
      send(8'd17);
      check("len17_err", {busy2, error2}, 2'b01);

      // start while in DATA with a byte presented: byte dropped, frame restarts
      in_valid = 1'b1;
      in_data  = 8'hAA;
      pulse_start();
      in_valid = 1'b0;
      check("restart_len", {busy, in_ready}, 2'b11);

      // gapped 3-byte frame
      send(8'd3);
      exp_q.push_back({8'd0, 8'h00});
      send(8'h00);
      idle(2);
      exp_q.push_back({8'd1, 8'h05});
      send(8'h05);
      idle(2);
      exp_q.push_back({8'd2, 8'h30});
      send(8'h30);
      send(8'h35);
      check("gap_run", {cpu_en, error}, 2'b10);
      check("gap_q", exp_q.size(), 0);

      // bytes in RUN are ignored
      in_valid = 1'b1;
      in_data  = 8'h55;
      @(negedge clk);
      check("run_ready", in_ready, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("run_hold", cpu_en, 1'b1);

      // reset in the middle of DATA
      pulse_start();
      send(8'd18);
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back({8'(i), prog[i]});
         send(prog[i]);
      end
      in_valid = 1'b1;
      in_data  = prog[5];
      check("pre_reset_load", mem_load, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_load", mem_load, 1'b0);
      check("async_outs", {in_ready, cpu_en, busy, done, error}, 5'b0);
      check("async_addr", {mem_address, mem_data}, 16'h0000);
      exp_q.delete();
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      d0 = done_cnt;
      pulse_start();
      frame(8'h19);
      check("post_reset_run", {cpu_en, error}, 2'b10);

      // reload from RUN
      pulse_start();
      check("reload_en_drop", cpu_en, 1'b0);
      send(8'd1);
      exp_q.push_back({8'd0, HALT, 4'b0000});
      send({HALT, 4'b0000});
      send(8'h30);
      check("reload_run", {cpu_en, done, error}, 3'b110);
      repeat (2) @(posedge clk);
      #1;
      check("reload_done_cnt", done_cnt, d0 + 2);
      check("final_q", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
